// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the Uart8 transmit arbiter.
// State encoding and the counter width rule live here so the future rx dispatcher can reuse them.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_e;

    localparam int BYTE_W = 8;

    // Counters hold values 0..max_val, so they need clog2(max_val+1) bits (at least one).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and Uart8-side signals around the transmit arbiter.
// The arbiter uses the slave modport; producers plus the Uart8 model use master.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic                        enable;
    logic [NUM_REQ-1:0]          reqValid;
    logic [BYTE_W*NUM_REQ-1:0]   reqData;
    logic [NUM_REQ-1:0]          reqLast;
    logic [NUM_REQ-1:0]          reqAck;
    logic [NUM_REQ-1:0]          grant;
    logic                        txEn;
    logic                        txStart;
    logic [BYTE_W-1:0]           txData;
    logic                        txBusy;
    logic                        txDone;
    logic                        busy;
    logic                        timeoutErr;

    modport slave (
        input  enable, reqValid, reqData, reqLast, txBusy, txDone,
        output reqAck, grant, txEn, txStart, txData, busy, timeoutErr
    );

    modport master (
        output enable, reqValid, reqData, reqLast, txBusy, txDone,
        input  reqAck, grant, txEn, txStart, txData, busy, timeoutErr
    );
endinterface

// File: rtl/uart_tx_arbiter_round_robin_pick.sv
// Combinational round-robin picker: first eligible request after last_i, wrapping.
// lock_mask_i restricts eligibility (all ones when no lock is held).
module uart_tx_arbiter_round_robin_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    input  logic [NUM_REQ-1:0] lock_mask_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);
    logic [NUM_REQ-1:0] eligible;
    int                 cand;

    assign eligible = req_i & lock_mask_i;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_i) + k) % NUM_REQ;
            if (!valid_o && eligible[cand]) begin
                valid_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one Uart8 transmitter among NUM_REQ byte sources,
// with packet lock so a multi-byte message is never interleaved with another source.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 0,
    parameter int START_TIMEOUT = 64,
    parameter int LOCK_IDLE_MAX = 4096
) (
    input logic              clk,
    input logic              rstN,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ST_W  = cnt_width(START_TIMEOUT);
    localparam int GP_W  = cnt_width(GAP_CYCLES);
    localparam int LK_W  = cnt_width(LOCK_IDLE_MAX);

    arb_state_e         state_q, state_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               last_q, last_d;
    logic               lock_q, lock_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [IDX_W-1:0]   lastIdx_q, lastIdx_d;
    logic               tmo_q, tmo_d;
    logic [ST_W-1:0]    startCnt_q, startCnt_d;
    logic [GP_W-1:0]    gapCnt_q, gapCnt_d;
    logic [LK_W-1:0]    lockCnt_q, lockCnt_d;

    logic [NUM_REQ-1:0] ownerOnehot, lockMask, pickOnehot;
    logic [IDX_W-1:0]   pickIdx;
    logic               pickValid, ownerValid, lockExpire, lockActive;

    // While locked the owner is always the last granted requester.
    assign ownerValid  = bus.reqValid[lastIdx_q];
    assign ownerOnehot = NUM_REQ'(1) << lastIdx_q;
    assign lockExpire  = lock_q && (state_q == ST_IDLE) && bus.enable && !ownerValid &&
                         (lockCnt_q >= LK_W'(LOCK_IDLE_MAX - 1));
    assign lockActive  = lock_q && !lockExpire;
    assign lockMask    = lockActive ? ownerOnehot : '1;

    uart_tx_arbiter_round_robin_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_round_robin_pick (
        .req_i       (bus.reqValid),
        .last_i      (lastIdx_q),
        .lock_mask_i (lockMask),
        .onehot_o    (pickOnehot),
        .idx_o       (pickIdx),
        .valid_o     (pickValid)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        last_d     = last_q;
        lock_d     = lock_q;
        grant_d    = grant_q;
        ack_d      = '0;
        lastIdx_d  = lastIdx_q;
        tmo_d      = 1'b0;
        startCnt_d = startCnt_q;
        gapCnt_d   = gapCnt_q;
        lockCnt_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (lock_q && !ownerValid) begin
                    lockCnt_d = lockCnt_q;
                    if (bus.enable && (lockCnt_q < LK_W'(LOCK_IDLE_MAX)))
                        lockCnt_d = lockCnt_q + 1'b1;
                end
                if (lockExpire) begin
                    lock_d  = 1'b0;
                    grant_d = '0;
                end
                if (bus.enable && pickValid) begin
                    data_d     = bus.reqData[{pickIdx, 3'b000} +: BYTE_W];
                    last_d     = bus.reqLast[pickIdx];
                    ack_d      = pickOnehot;
                    grant_d    = pickOnehot;
                    lastIdx_d  = pickIdx;
                    startCnt_d = '0;
                    lockCnt_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bus.txBusy) begin
                    state_d = ST_WAIT_DONE;
                end else if (startCnt_q >= ST_W'(START_TIMEOUT - 1)) begin
                    // Uart8 never answered: drop the byte and any packet in progress.
                    tmo_d   = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    startCnt_d = startCnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.txDone) begin
                    lock_d   = !last_q;
                    gapCnt_d = '0;
                    if (last_q)
                        grant_d = '0;
                    state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gapCnt_q >= GP_W'(GAP_CYCLES - 1))
                    state_d = ST_IDLE;
                else
                    gapCnt_d = gapCnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            last_q     <= 1'b0;
            lock_q     <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            lastIdx_q  <= IDX_W'(NUM_REQ - 1);
            tmo_q      <= 1'b0;
            startCnt_q <= '0;
            gapCnt_q   <= '0;
            lockCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            last_q     <= last_d;
            lock_q     <= lock_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            lastIdx_q  <= lastIdx_d;
            tmo_q      <= tmo_d;
            startCnt_q <= startCnt_d;
            gapCnt_q   <= gapCnt_d;
            lockCnt_q  <= lockCnt_d;
        end
    end

    assign bus.reqAck     = ack_q;
    assign bus.grant      = grant_q;
    assign bus.txEn       = bus.enable;
    assign bus.txStart    = (state_q == ST_START);
    assign bus.txData     = data_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.timeoutErr = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: Uart8 behavioural model, queue-driven requesters
// and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    typedef struct packed { logic [7:0] data; logic last; } byte_t;
    typedef struct { int req; logic [7:0] data; logic last; } item_t;

    logic clk;
    logic rstN;
    int   checks = 0;
    int   errors = 0;

    byte_t      pq[NR][$];
    item_t      ack_log[$];
    item_t      exp_log[$];
    logic [7:0] tx_log[$];
    bit         uart_mute;
    bit         multi_ack;
    bit         drv_timeout;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .GAP_CYCLES    (0),
        .START_TIMEOUT (64),
        .LOCK_IDLE_MAX (16)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Uart8 model: answers txStart with txBusy after 0..2 cycles, then a one-cycle txDone.
    initial begin
        int st;
        int cnt;
        st = 0;
        cnt = 0;
        bus.txBusy = 1'b0;
        bus.txDone = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                st = 0;
                bus.txBusy = 1'b0;
                bus.txDone = 1'b0;
            end else begin
                case (st)
                    0: begin
                        bus.txDone = 1'b0;
                        if (bus.txStart && !uart_mute) begin
                            cnt = $urandom_range(0, 2);
                            st = 1;
                        end
                    end
                    1: if (cnt == 0) begin
                        bus.txBusy = 1'b1;
                        tx_log.push_back(bus.txData);
                        cnt = $urandom_range(2, 5);
                        st = 2;
                    end else cnt--;
                    2: if (cnt == 0) begin
                        bus.txBusy = 1'b0;
                        bus.txDone = 1'b1;
                        st = 3;
                    end else cnt--;
                    default: begin
                        bus.txDone = 1'b0;
                        st = 0;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic present();
        for (int i = 0; i < NR; i++) begin
            if (pq[i].size() > 0) begin
                bus.reqValid[i]        = 1'b1;
                bus.reqData[8*i +: 8]  = pq[i][0].data;
                bus.reqLast[i]         = pq[i][0].last;
            end else begin
                bus.reqValid[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rstN         = 1'b0;
        bus.enable   = 1'b0;
        bus.reqValid = '0;
        bus.reqData  = '0;
        bus.reqLast  = '0;
        uart_mute    = 1'b0;
        for (int i = 0; i < NR; i++) pq[i].delete();
        repeat (3) tick();
        tx_log.delete();
        ack_log.delete();
        rstN       = 1'b1;
        bus.enable = 1'b1;
        tick();
    endtask

    // Presents queued bytes; pops a byte when its reqAck is seen.
    task automatic drive_queues(input int max_cycles);
        item_t it;
        bit    empty;
        drv_timeout = 1'b0;
        multi_ack   = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            tick();
            if (bus.reqAck != '0) begin
                if ($countones(bus.reqAck) != 1) multi_ack = 1'b1;
                for (int i = 0; i < NR; i++) begin
                    if (bus.reqAck[i] && pq[i].size() > 0) begin
                        it.req  = i;
                        it.data = pq[i][0].data;
                        it.last = pq[i][0].last;
                        ack_log.push_back(it);
                        void'(pq[i].pop_front());
                    end
                end
            end
            present();
            empty = 1'b1;
            for (int i = 0; i < NR; i++) if (pq[i].size() > 0) empty = 1'b0;
            if (empty && !bus.busy) return;
        end
        drv_timeout = 1'b1;
    endtask

    task automatic wait_idle(input int max_cycles);
        drv_timeout = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            tick();
            if (!bus.busy) return;
        end
        drv_timeout = 1'b1;
    endtask

    // Reference: packets are served whole, next owner is the first non-empty queue after the last one.
    task automatic build_expect(input int start_ptr);
        byte_t mq[NR][$];
        byte_t b;
        item_t it;
        int    p;
        int    found;
        for (int i = 0; i < NR; i++) mq[i] = pq[i];
        exp_log.delete();
        p = start_ptr;
        forever begin
            found = -1;
            for (int k = 1; k <= NR; k++)
                if (found < 0 && mq[(p + k) % NR].size() > 0) found = (p + k) % NR;
            if (found < 0) break;
            do begin
                b = mq[found].pop_front();
                it.req  = found;
                it.data = b.data;
                it.last = b.last;
                exp_log.push_back(it);
            end while (!b.last && mq[found].size() > 0);
            p = found;
        end
    endtask

    task automatic test_reset();
        do_reset();
        rstN = 1'b0;
        #1;
        checks++; if (bus.reqAck !== 4'b0000) begin errors++; $display("FAIL reset_reqAck got %b want 0000", bus.reqAck); end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
        checks++; if (bus.txStart !== 1'b0) begin errors++; $display("FAIL reset_txStart got %b want 0", bus.txStart); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_timeoutErr got %b want 0", bus.timeoutErr); end
        checks++; if (bus.txData !== 8'h00) begin errors++; $display("FAIL reset_txData got %h want 00", bus.txData); end
        bus.enable = 1'b0;
        #1;
        checks++; if (bus.txEn !== 1'b0) begin errors++; $display("FAIL txEn_low got %b want 0", bus.txEn); end
        bus.enable = 1'b1;
        #1;
        checks++; if (bus.txEn !== 1'b1) begin errors++; $display("FAIL txEn_high got %b want 1", bus.txEn); end
        tick();
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.reqValid = 4'b0010;
        bus.reqData[15:8] = 8'h35;
        bus.reqLast = 4'b0010;
        tick();
        checks++; if (bus.reqAck !== 4'b0010) begin errors++; $display("FAIL single_ack got %b want 0010", bus.reqAck); end
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b want 0010", bus.grant); end
        checks++; if (bus.txStart !== 1'b1) begin errors++; $display("FAIL single_txStart got %b want 1", bus.txStart); end
        checks++; if (bus.txData !== 8'h35) begin errors++; $display("FAIL single_txData got %h want 35", bus.txData); end
        bus.reqValid = '0;
        tick();
        checks++; if (bus.reqAck !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse got %b want 0000", bus.reqAck); end
        drv_timeout = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (bus.txBusy) begin drv_timeout = 1'b0; break; end
            tick();
        end
        tick();
        checks++; if (drv_timeout || bus.txStart !== 1'b0) begin errors++; $display("FAIL single_txStart_drop got %b timeout %0d want 0", bus.txStart, drv_timeout); end
        drv_timeout = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (bus.txDone) begin drv_timeout = 1'b0; break; end
            tick();
        end
        tick();
        checks++; if (drv_timeout || bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_done got %b timeout %0d want 0", bus.busy, drv_timeout); end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_grant_release got %b want 0000", bus.grant); end
        checks++; if (tx_log.size() != 1 || tx_log[0] !== 8'h35) begin errors++; $display("FAIL single_loopback got %0d bytes first %h want 1 byte 35", tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'h00); end
    endtask

    task automatic test_fairness();
        byte_t b;
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 2; j++) begin
                b.data = 8'($urandom);
                b.last = 1'b1;
                pq[i].push_back(b);
            end
        build_expect(NR - 1);
        drive_queues(3000);
        checks++; if (drv_timeout) begin errors++; $display("FAIL fair_timeout got 1 want 0"); end
        checks++; if (multi_ack) begin errors++; $display("FAIL fair_onehot_ack got multi want onehot"); end
        checks++; if (ack_log.size() != 8) begin errors++; $display("FAIL fair_count got %0d want 8", ack_log.size()); end
        for (int i = 0; i < ack_log.size() && i < 8; i++) begin
            checks++;
            if (ack_log[i].req != (i % NR) || ack_log[i].data !== exp_log[i].data) begin
                errors++; $display("FAIL fair_order[%0d] got req%0d %h want req%0d %h", i, ack_log[i].req, ack_log[i].data, i % NR, exp_log[i].data);
            end
        end
        for (int i = 0; i < tx_log.size() && i < exp_log.size(); i++) begin
            checks++;
            if (tx_log[i] !== exp_log[i].data) begin errors++; $display("FAIL fair_txbyte[%0d] got %h want %h", i, tx_log[i], exp_log[i].data); end
        end
    endtask

    task automatic test_packet_lock();
        byte_t b;
        do_reset();
        b.data = 8'h11; b.last = 1'b1; pq[1].push_back(b);
        drive_queues(500);
        ack_log.delete();
        tx_log.delete();
        b.data = 8'hA1; b.last = 1'b0; pq[2].push_back(b);
        b.data = 8'hA2; b.last = 1'b1; pq[2].push_back(b);
        b.data = 8'h5C; b.last = 1'b1; pq[0].push_back(b);
        build_expect(1);
        drive_queues(1000);
        checks++; if (drv_timeout || ack_log.size() != 3 || tx_log.size() != 3) begin
            errors++; $display("FAIL lock_count got acks %0d bytes %0d timeout %0d want 3 3 0", ack_log.size(), tx_log.size(), drv_timeout);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ack_log[i].req != exp_log[i].req || tx_log[i] !== exp_log[i].data) begin
                    errors++; $display("FAIL lock_order[%0d] got req%0d %h want req%0d %h", i, ack_log[i].req, tx_log[i], exp_log[i].req, exp_log[i].data);
                end
            end
        end
    endtask

    task automatic test_random();
        byte_t b;
        int    ptr;
        int    n;
        do_reset();
        ptr = NR - 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NR; i++) begin
                n = $urandom_range(0, 4);
                for (int j = 0; j < n; j++) begin
                    b.data = 8'($urandom);
                    b.last = (j == n - 1) ? 1'b1 : 1'($urandom);
                    pq[i].push_back(b);
                end
            end
            build_expect(ptr);
            ack_log.delete();
            tx_log.delete();
            drive_queues(5000);
            checks++; if (drv_timeout || multi_ack) begin errors++; $display("FAIL rand_run[%0d] got timeout %0d multi %0d want 0 0", r, drv_timeout, multi_ack); end
            checks++; if (ack_log.size() != exp_log.size() || tx_log.size() != exp_log.size()) begin
                errors++; $display("FAIL rand_count[%0d] got acks %0d bytes %0d want %0d", r, ack_log.size(), tx_log.size(), exp_log.size());
            end else begin
                for (int i = 0; i < exp_log.size(); i++) begin
                    checks++;
                    if (ack_log[i].req != exp_log[i].req || tx_log[i] !== exp_log[i].data) begin
                        errors++; $display("FAIL rand_item[%0d][%0d] got req%0d %h want req%0d %h", r, i, ack_log[i].req, tx_log[i], exp_log[i].req, exp_log[i].data);
                    end
                end
            end
            if (exp_log.size() > 0) ptr = exp_log[exp_log.size() - 1].req;
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        uart_mute = 1'b1;
        bus.reqValid = 4'b0001;
        bus.reqData[7:0] = 8'h77;
        bus.reqLast = 4'b0000;
        tick();
        checks++; if (bus.reqAck !== 4'b0001 || bus.txStart !== 1'b1) begin errors++; $display("FAIL tmo_start got ack %b txStart %b want 0001 1", bus.reqAck, bus.txStart); end
        bus.reqValid = '0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            n++;
            if (bus.timeoutErr) break;
        end
        checks++; if (n != 64) begin errors++; $display("FAIL tmo_latency got %0d want 64", n); end
        checks++; if (bus.txStart !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got txStart %b busy %b want 0 0", bus.txStart, bus.busy); end
        tick();
        checks++; if (bus.timeoutErr !== 1'b0) begin errors++; $display("FAIL tmo_pulse got %b want 0", bus.timeoutErr); end
        uart_mute = 1'b0;
        bus.reqValid = 4'b0010;
        bus.reqData[15:8] = 8'h88;
        bus.reqLast = 4'b0010;
        tick();
        checks++; if (bus.reqAck !== 4'b0010) begin errors++; $display("FAIL tmo_next_ack got %b want 0010", bus.reqAck); end
        bus.reqValid = '0;
        wait_idle(200);
        checks++; if (drv_timeout || tx_log.size() != 1 || tx_log[0] !== 8'h88) begin
            errors++; $display("FAIL tmo_next_byte got %0d bytes timeout %0d want one byte 88", tx_log.size(), drv_timeout);
        end
    endtask

    task automatic test_lock_release();
        int n;
        do_reset();
        bus.reqValid = 4'b1000;
        bus.reqData[31:24] = 8'hD3;
        bus.reqLast = 4'b0000;
        tick();
        checks++; if (bus.reqAck !== 4'b1000) begin errors++; $display("FAIL lrel_first_ack got %b want 1000", bus.reqAck); end
        bus.reqValid = 4'b0010;
        bus.reqData[15:8] = 8'h1B;
        bus.reqLast = 4'b0010;
        wait_idle(200);
        checks++; if (drv_timeout || bus.grant !== 4'b1000) begin errors++; $display("FAIL lrel_owner_hold got %b timeout %0d want 1000", bus.grant, drv_timeout); end
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            n++;
            if (bus.reqAck != '0) break;
        end
        checks++; if (n != 16 || bus.reqAck !== 4'b0010) begin errors++; $display("FAIL lrel_latency got %0d ack %b want 16 0010", n, bus.reqAck); end
        bus.reqValid = '0;
        wait_idle(200);
        checks++; if (tx_log.size() != 2 || tx_log[0] !== 8'hD3 || tx_log[1] !== 8'h1B) begin
            errors++; $display("FAIL lrel_bytes got %0d bytes want D3 1B", tx_log.size());
        end
    endtask

    task automatic test_reset_enable();
        int acks;
        do_reset();
        bus.reqValid = 4'b0100;
        bus.reqData[23:16] = 8'h42;
        bus.reqLast = 4'b0100;
        tick();
        bus.reqValid = '0;
        drv_timeout = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.txBusy) begin drv_timeout = 1'b0; break; end
        end
        tick();
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (drv_timeout || bus.busy !== 1'b0 || bus.txStart !== 1'b0) begin errors++; $display("FAIL midreset_state got busy %b txStart %b timeout %0d want 0 0 0", bus.busy, bus.txStart, drv_timeout); end
        checks++; if (bus.grant !== 4'b0000 || bus.reqAck !== 4'b0000 || bus.txData !== 8'h00) begin
            errors++; $display("FAIL midreset_outputs got grant %b ack %b data %h want 0000 0000 00", bus.grant, bus.reqAck, bus.txData);
        end
        tick();
        rstN = 1'b1;
        tx_log.delete();
        tick();
        bus.reqValid = 4'b0011;
        bus.reqData[7:0] = 8'h60;
        bus.reqData[15:8] = 8'h61;
        bus.reqLast = 4'b0011;
        tick();
        checks++; if (bus.reqAck !== 4'b0001) begin errors++; $display("FAIL en_first_ack got %b want 0001", bus.reqAck); end
        bus.enable = 1'b0;
        bus.reqValid = 4'b0010;
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.reqAck != '0) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL en_low_no_ack got %0d want 0", acks); end
        checks++; if (bus.busy !== 1'b0 || tx_log.size() != 1 || tx_log[0] !== 8'h60) begin
            errors++; $display("FAIL en_low_byte_done got busy %b bytes %0d want 0 and one byte 60", bus.busy, tx_log.size());
        end
        checks++; if (bus.txEn !== 1'b0) begin errors++; $display("FAIL en_low_txEn got %b want 0", bus.txEn); end
        bus.enable = 1'b1;
        tick();
        checks++; if (bus.reqAck !== 4'b0010) begin errors++; $display("FAIL en_resume_ack got %b want 0010", bus.reqAck); end
        bus.reqValid = '0;
        wait_idle(200);
    endtask

    initial begin
        rstN = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_packet_lock();
        test_random();
        test_timeout();
        test_lock_release();
        test_reset_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
